cam_write_ctrl: RTL and testbench

- Write-side controller for the 8-entry, 16-bit CAM. The CAM is the lookup side; this block is the side that programs it.
- Accepts append, invalidate and flush commands over a valid/ready handshake and allocates free entries. Drives the CAM's entry write port and tracks the occupancy bitmap.
- The CAM storage has no reset, so this block clears every entry automatically after reset.

---
 rtl/cam_write_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cam_write_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_write_ctrl.sv
// Write-side controller for the CAM: allocates free entries on APPEND, clears
// entries on INVALIDATE/FLUSH, and wipes the whole array after every reset.
module cam_write_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_vbit,
  output logic              o_resp_valid,
  output logic [ADDR_W-1:0] o_resp_addr,
  output logic              o_resp_err,
  output logic [ENTRIES-1:0] o_occ,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full
);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_APPEND = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  state_t              r_state;
  logic [CNT_W-1:0]    r_flush_idx;
  logic [ENTRIES-1:0]  r_occ;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_wr_vbit;
  logic                r_resp_valid;
  logic [ADDR_W-1:0]   r_resp_addr;
  logic                r_resp_err;

  logic [ADDR_W-1:0]   w_free_idx;
  logic                w_has_free;
  logic [CNT_W-1:0]    w_count;

  // Lowest free entry wins; scanning downward lets index 0 overwrite last.
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_occ[i]) begin
        w_free_idx = ADDR_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_count = w_count + CNT_W'(r_occ[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_FLUSH;
      r_flush_idx  <= '0;
      r_occ        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_vbit    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_FLUSH: begin
          if (r_flush_idx == CNT_W'(ENTRIES)) begin
            r_resp_valid <= 1'b1;
            r_resp_addr  <= ADDR_W'(ENTRIES - 1);
            r_resp_err   <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_wr_en     <= 1'b1;
            r_wr_addr   <= r_flush_idx[ADDR_W-1:0];
            r_wr_data   <= '0;
            r_wr_vbit   <= 1'b0;
            r_flush_idx <= r_flush_idx + CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (i_cmd_valid) begin
            case (i_cmd_op)
              OP_NOP: begin
                r_resp_valid <= 1'b1;
                r_resp_addr  <= '0;
                r_resp_err   <= 1'b0;
                r_state      <= S_ISSUE;
              end
              OP_APPEND: begin
                r_resp_valid <= 1'b1;
                r_state      <= S_ISSUE;
                if (w_has_free) begin
                  r_wr_en            <= 1'b1;
                  r_wr_addr          <= w_free_idx;
                  r_wr_data          <= i_cmd_data;
                  r_wr_vbit          <= 1'b1;
                  r_resp_addr        <= w_free_idx;
                  r_resp_err         <= 1'b0;
                  r_occ[w_free_idx]  <= 1'b1;
                end else begin
                  r_resp_addr <= '0;
                  r_resp_err  <= 1'b1;
                end
              end
              OP_INVAL: begin
                r_resp_valid <= 1'b1;
                r_resp_addr  <= i_cmd_addr;
                r_state      <= S_ISSUE;
                if (r_occ[i_cmd_addr]) begin
                  r_wr_en            <= 1'b1;
                  r_wr_addr          <= i_cmd_addr;
                  r_wr_data          <= '0;
                  r_wr_vbit          <= 1'b0;
                  r_resp_err         <= 1'b0;
                  r_occ[i_cmd_addr]  <= 1'b0;
                end else begin
                  r_resp_err <= 1'b1;
                end
              end
              OP_FLUSH: begin
                // Issue write 0 on the accepting edge so the first strobe lands next cycle.
                r_occ       <= '0;
                r_wr_en     <= 1'b1;
                r_wr_addr   <= '0;
                r_wr_data   <= '0;
                r_wr_vbit   <= 1'b0;
                r_flush_idx <= CNT_W'(1);
                r_state     <= S_FLUSH;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end

        S_ISSUE: r_state <= S_IDLE;

        default: begin
          r_flush_idx <= '0;
          r_state     <= S_FLUSH;
        end
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_vbit    = r_wr_vbit;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_addr  = r_resp_addr;
  assign o_resp_err   = r_resp_err;
  assign o_occ        = r_occ;
  assign o_count      = w_count;
  assign o_full       = (w_count == CNT_W'(ENTRIES));

endmodule

// File: tb/tb_cam_write_ctrl.sv
// Self-checking bench for cam_write_ctrl: command table plus a scoreboard that
// matches every write strobe and response pulse against queued expectations.
module tb_cam_write_ctrl;

  localparam logic [1:0] OP_APPEND = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [15:0] cmdData;
  logic [2:0]  cmdAddr;
  logic        wrEn;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic        wrVbit;
  logic        respValid;
  logic [2:0]  respAddr;
  logic        respErr;
  logic [7:0]  occ;
  logic [3:0]  count;
  logic        full;

  cam_write_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_cmd_valid  (cmdValid),
    .o_cmd_ready  (cmdReady),
    .i_cmd_op     (cmdOp),
    .i_cmd_data   (cmdData),
    .i_cmd_addr   (cmdAddr),
    .o_wr_en      (wrEn),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_wr_vbit    (wrVbit),
    .o_resp_valid (respValid),
    .o_resp_addr  (respAddr),
    .o_resp_err   (respErr),
    .o_occ        (occ),
    .o_count      (count),
    .o_full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [2:0]  addr;
    logic        expWr;
    logic [2:0]  expAddr;
    logic        expErr;
    logic [3:0]  expCount;
    logic [7:0]  expOcc;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        vbit;
  } wr_t;

  typedef struct {
    logic [2:0] addr;
    logic       err;
  } rsp_t;

  vec_t vecs[$];
  wr_t  wrQ[$];
  rsp_t respQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic [1:0] op, input logic [15:0] data, input logic [2:0] addr,
                        input logic expWr, input logic [2:0] expAddr, input logic expErr,
                        input logic [3:0] expCount, input logic [7:0] expOcc);
    vec_t v;
    v.op = op; v.data = data; v.addr = addr; v.expWr = expWr; v.expAddr = expAddr;
    v.expErr = expErr; v.expCount = expCount; v.expOcc = expOcc;
    vecs.push_back(v);
  endtask

  task automatic pushFlush();
    for (int i = 0; i < 8; i++) wrQ.push_back('{addr: 3'(i), data: 16'h0000, vbit: 1'b0});
    respQ.push_back('{addr: 3'd7, err: 1'b0});
  endtask

  // Scoreboard: every strobe seen by the DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (rstN) begin
      if (wrEn) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpectedWrite", {wrAddr, wrData, wrVbit}, 32'hFFFFFFFF);
        end else begin
          wr_t e;
          e = wrQ.pop_front();
          checkOutput("writeBeat", {12'h0, wrAddr, wrData, wrVbit}, {12'h0, e.addr, e.data, e.vbit});
        end
      end
      if (respValid) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpectedResp", {respAddr, respErr}, 32'hFFFFFFFF);
        end else begin
          rsp_t r;
          r = respQ.pop_front();
          checkOutput("respBeat", {28'h0, respAddr, respErr}, {28'h0, r.addr, r.err});
        end
      end
    end
  end

  task automatic waitReady();
    int cycles = 0;
    while (!cmdReady && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("readyWithinBudget", cmdReady, 1);
  endtask

  // Command is held on the bus until the controller accepts it.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data, input logic [2:0] addr);
    int cycles = 0;
    cmdValid = 1'b1; cmdOp = op; cmdData = data; cmdAddr = addr;
    while (!cmdReady && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!cmdReady) checkOutput("acceptTimeout", cmdReady, 1);
    @(posedge clk); #1;
    cmdValid = 1'b0; cmdOp = 2'b00; cmdData = 16'hxxxx; cmdAddr = 3'bxxx;
  endtask

  initial begin
    rstN = 1'b0; cmdValid = 1'b0; cmdOp = 2'b00; cmdData = 16'h0; cmdAddr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstWrEn", wrEn, 0);
    checkOutput("rstReady", cmdReady, 0);
    checkOutput("rstRespValid", respValid, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstFull", full, 0);

    pushFlush();
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    waitReady();
    checkOutput("postFlushCount", count, 0);

    addVec(OP_APPEND, 16'h0003, 3'd0, 1, 3'd0, 0, 4'd1, 8'b0000_0001);
    addVec(OP_APPEND, 16'h0004, 3'd0, 1, 3'd1, 0, 4'd2, 8'b0000_0011);
    addVec(OP_APPEND, 16'h00F0, 3'd0, 1, 3'd2, 0, 4'd3, 8'b0000_0111);
    addVec(OP_APPEND, 16'h1003, 3'd0, 1, 3'd3, 0, 4'd4, 8'b0000_1111);
    addVec(OP_APPEND, 16'h1004, 3'd0, 1, 3'd4, 0, 4'd5, 8'b0001_1111);
    addVec(OP_APPEND, 16'h1005, 3'd0, 1, 3'd5, 0, 4'd6, 8'b0011_1111);
    addVec(OP_APPEND, 16'h1006, 3'd0, 1, 3'd6, 0, 4'd7, 8'b0111_1111);
    addVec(OP_APPEND, 16'h1007, 3'd0, 1, 3'd7, 0, 4'd8, 8'b1111_1111);
    addVec(OP_APPEND, 16'hBEEF, 3'd0, 0, 3'd0, 1, 4'd8, 8'b1111_1111);
    addVec(OP_INVAL,  16'h0000, 3'd3, 1, 3'd3, 0, 4'd7, 8'b1111_0111);
    addVec(OP_APPEND, 16'h1234, 3'd0, 1, 3'd3, 0, 4'd8, 8'b1111_1111);
    addVec(OP_INVAL,  16'h0000, 3'd3, 1, 3'd3, 0, 4'd7, 8'b1111_0111);
    addVec(OP_INVAL,  16'h0000, 3'd3, 0, 3'd3, 1, 4'd7, 8'b1111_0111);
    addVec(OP_INVAL,  16'h0000, 3'd6, 1, 3'd6, 0, 4'd6, 8'b1011_0111);
    addVec(OP_INVAL,  16'h0000, 3'd7, 1, 3'd7, 0, 4'd5, 8'b0011_0111);
    addVec(OP_APPEND, 16'h00AA, 3'd0, 1, 3'd3, 0, 4'd6, 8'b0011_1111);
    addVec(OP_INVAL,  16'h0000, 3'd0, 1, 3'd0, 0, 4'd5, 8'b0011_1110);
    addVec(OP_FLUSH,  16'h0000, 3'd0, 0, 3'd7, 0, 4'd0, 8'b0000_0000);
    addVec(OP_APPEND, 16'h5555, 3'd0, 1, 3'd0, 0, 4'd1, 8'b0000_0001);

    foreach (vecs[i]) begin
      if (vecs[i].op == OP_FLUSH) begin
        pushFlush();
      end else begin
        if (vecs[i].expWr)
          wrQ.push_back('{addr: vecs[i].expAddr,
                          data: (vecs[i].op == OP_APPEND) ? vecs[i].data : 16'h0000,
                          vbit: (vecs[i].op == OP_APPEND)});
        respQ.push_back('{addr: vecs[i].expAddr, err: vecs[i].expErr});
      end
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].addr);
      checkOutput($sformatf("vec%0d_count", i), count, vecs[i].expCount);
      checkOutput($sformatf("vec%0d_occ", i), occ, vecs[i].expOcc);
      checkOutput($sformatf("vec%0d_full", i), full, (vecs[i].expCount == 4'd8));
    end
    waitReady();

    // Reset in the middle of a flush must restart the wipe from entry 0.
    pushFlush();
    applyStimulus(OP_FLUSH, 16'h0, 3'd0);
    begin
      int cycles = 0;
      while (!(wrEn && wrAddr == 3'd3) && cycles < 50) begin
        @(posedge clk); #1;
        cycles++;
      end
      checkOutput("flushFourthWrite", (wrEn && wrAddr == 3'd3), 1);
    end
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstWrEn", wrEn, 0);
    checkOutput("midRstReady", cmdReady, 0);
    checkOutput("midRstWrAddr", wrAddr, 0);
    checkOutput("midRstCount", count, 0);
    wrQ.delete();
    respQ.delete();
    pushFlush();
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    waitReady();
    checkOutput("afterRestartCount", count, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("writesDrained", wrQ.size(), 0);
    checkOutput("respsDrained", respQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
